// File: rtl/alu_issue_if.sv
// Handshake and datapath bundle around the ALU issue stage.
// master: the issue block (drives in_ready, the ALU operand bus and the result stream).
// slave : its surroundings (decode upstream, the ALU, writeback downstream).
interface alu_issue_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) ();
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_f7b5;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [RD_W-1:0] in_rd;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_zero;
  logic            out_illegal;

  modport master (
    input  in_valid, in_opcode, in_funct3, in_f7b5, in_rs1, in_rs2, in_pc, in_imm, in_rd,
    input  alu_result, out_ready,
    output in_ready, alu_op, alu_a, alu_b,
    output out_valid, out_result, out_rd, out_zero, out_illegal
  );

  modport slave (
    output in_valid, in_opcode, in_funct3, in_f7b5, in_rs1, in_rs2, in_pc, in_imm, in_rd,
    output alu_result, out_ready,
    input  in_ready, alu_op, alu_a, alu_b,
    input  out_valid, out_result, out_rd, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage ALU issue: decodes RV32I opcode/funct3/funct7 into a 5-bit ALU op, picks
// operands, presents them to an external combinational ALU from an issue register (S1) and
// captures the ALU result in a result register (S2). Valid/ready on both sides, full backpressure.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_issue_if.master   bus
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 -> ALU op; alt selects SUB for 000 and SRA for 101
  function automatic logic [4:0] f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_to_op = OP_SLL;
      3'b010:  f3_to_op = OP_SLT;
      3'b011:  f3_to_op = OP_SLTU;
      3'b100:  f3_to_op = OP_XOR;
      3'b101:  f3_to_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_to_op = OP_OR;
      3'b111:  f3_to_op = OP_AND;
      default: f3_to_op = OP_ADD;
    endcase
  endfunction

  logic            s1_valid_r;
  logic            s2_valid_r;
  logic [RD_W-1:0] s1_rd_r;
  logic            s1_illegal_r;
  logic            s2_adv_s;
  logic            s1_adv_s;
  logic            accept_s;
  logic [4:0]      dec_op_s;
  logic [XLEN-1:0] dec_a_s;
  logic [XLEN-1:0] dec_b_s;
  logic [XLEN-1:0] iss_b_s;
  logic            dec_illegal_s;

  assign s2_adv_s     = ~s2_valid_r | bus.out_ready;
  assign s1_adv_s     = s1_valid_r & s2_adv_s;
  assign bus.in_ready = ~flush & (~s1_valid_r | s2_adv_s);
  assign accept_s     = bus.in_valid & bus.in_ready;

  assign bus.out_valid = s2_valid_r;
  assign bus.out_zero  = (bus.out_result == {XLEN{1'b0}});

  // Decode the incoming op into ALU op code and raw operands
  always_comb begin
    dec_op_s      = OP_ADD;
    dec_a_s       = {XLEN{1'b0}};
    dec_b_s       = {XLEN{1'b0}};
    dec_illegal_s = 1'b0;
    case (bus.in_opcode)
      OPC_OP: begin
        dec_op_s = f3_to_op(bus.in_funct3, bus.in_f7b5);
        dec_a_s  = bus.in_rs1;
        dec_b_s  = bus.in_rs2;
      end
      OPC_OP_IMM: begin
        // ADDI has no SUB form: funct7 bit only matters for the right shift
        dec_op_s = f3_to_op(bus.in_funct3, bus.in_f7b5 & (bus.in_funct3 == 3'b101));
        dec_a_s  = bus.in_rs1;
        dec_b_s  = bus.in_imm;
      end
      OPC_LUI: begin
        dec_b_s = bus.in_imm;
      end
      OPC_AUIPC: begin
        dec_a_s = bus.in_pc;
        dec_b_s = bus.in_imm;
      end
      OPC_LOAD, OPC_STORE: begin
        dec_a_s = bus.in_rs1;
        dec_b_s = bus.in_imm;
      end
      OPC_BRANCH: begin
        dec_op_s = OP_SUB;
        dec_a_s  = bus.in_rs1;
        dec_b_s  = bus.in_rs2;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Shifts only see the 5-bit shift amount on the operand bus
  always_comb begin
    iss_b_s = dec_b_s;
    if ((dec_op_s == OP_SLL) || (dec_op_s == OP_SRL) || (dec_op_s == OP_SRA)) begin
      iss_b_s = {{(XLEN-5){1'b0}}, dec_b_s[4:0]};
    end else begin
      iss_b_s = dec_b_s;
    end
  end

  // Issue stage: load on accept, empty on advance, alu_* keep last value when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      bus.alu_op   <= OP_ADD;
      bus.alu_a    <= {XLEN{1'b0}};
      bus.alu_b    <= {XLEN{1'b0}};
      s1_rd_r      <= {RD_W{1'b0}};
      s1_illegal_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r   <= 1'b1;
      bus.alu_op   <= dec_op_s;
      bus.alu_a    <= dec_a_s;
      bus.alu_b    <= iss_b_s;
      s1_rd_r      <= bus.in_rd;
      s1_illegal_r <= dec_illegal_s;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Result stage: capture ALU output when S1 moves, drop when writeback takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r      <= 1'b0;
      bus.out_result  <= {XLEN{1'b0}};
      bus.out_rd      <= {RD_W{1'b0}};
      bus.out_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r      <= 1'b1;
      bus.out_result  <= bus.alu_result;
      bus.out_rd      <= s1_rd_r;
      bus.out_illegal <= s1_illegal_r;
    end else if (bus.out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

endmodule
